flow_ctrl: RTL and testbench

FLOW_CTRL -- requirements
Module: flow_ctrl

---
 rtl/flow_ctrl_pkg.sv | 34 +++
 rtl/flow_ctrl_btn_edge.sv | 37 +++
 rtl/flow_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_flow_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/flow_ctrl_pkg.sv
// ============================================================================
// Module   : flow_defs (package)
// Brief    : Shared encodings for the flow_ctrl light-chaser controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package flow_defs;

    // Controller states; the encoding is exposed directly on the State port.
    typedef enum logic [1:0] {
        ST_INIT  = 2'b00,
        ST_FWD   = 2'b01,
        ST_BWD   = 2'b10,
        ST_PAUSE = 2'b11
    } state_t;

    // Display command codes driven on Dir.
    localparam logic [1:0] DIR_HOLD = 2'b00;
    localparam logic [1:0] DIR_HOME = 2'b01;
    localparam logic [1:0] DIR_DEC  = 2'b10;
    localparam logic [1:0] DIR_INC  = 2'b11;

    // Last lit position of the 16-light display.
    localparam logic [3:0] POS_MAX = 4'd15;

    // True in the states where the step counter runs.
    function automatic logic is_run(input state_t s);
        return (s == ST_FWD) || (s == ST_BWD);
    endfunction

endpackage

`default_nettype wire

// File: rtl/flow_ctrl_btn_edge.sv
// ============================================================================
// Module   : btn_edge
// Brief    : Two-flop synchronizer followed by a rising-edge detector; emits
//            one single-cycle pulse per low-to-high transition of btn.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic prev;

    // Synchronize the asynchronous button and keep one delayed copy for edge detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign pulse = sync2 & ~prev;

endmodule

`default_nettype wire

// File: rtl/flow_ctrl.sv
// ============================================================================
// Module   : flow_ctrl
// Brief    : Light-chaser controller: steps a 16-position display forward or
//            backward at a selectable rate, with pause, home and ping-pong.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module flow_ctrl
    import flow_defs::*;
#(
    parameter int TICK_DIV = 25000000
) (
    input  logic       CLK_in,
    input  logic       RST_in,
    input  logic       Btn_fwd,
    input  logic       Btn_bwd,
    input  logic       Btn_pause,
    input  logic       Btn_home,
    input  logic       Bounce,
    input  logic [1:0] Speed,
    output logic [1:0] Dir,
    output logic [3:0] Pos,
    output logic [1:0] State,
    output logic       Tick
);

    localparam int              CNT_W   = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state, state_n;
    state_t           pause_dir, pause_dir_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       pos_n;
    logic [1:0]       dir_n;
    logic             tick_n;
    logic             pend_fwd, pend_bwd, pend_pause;
    logic             pend_fwd_n, pend_bwd_n, pend_pause_n;

    logic             p_fwd, p_bwd, p_pause, p_home;
    logic             cmd_fwd, cmd_bwd, cmd_pause, cmd_home;
    logic             go_fwd, go_bwd;
    logic [31:0]      term;
    logic             hit;

    btn_edge u_edge_fwd   (.clk(CLK_in), .rst(RST_in), .btn(Btn_fwd),   .pulse(p_fwd));
    btn_edge u_edge_bwd   (.clk(CLK_in), .rst(RST_in), .btn(Btn_bwd),   .pulse(p_bwd));
    btn_edge u_edge_pause (.clk(CLK_in), .rst(RST_in), .btn(Btn_pause), .pulse(p_pause));
    btn_edge u_edge_home  (.clk(CLK_in), .rst(RST_in), .btn(Btn_home),  .pulse(p_home));

    // Commands seen during the INIT cycle are replayed one cycle later.
    assign cmd_fwd   = p_fwd   | pend_fwd;
    assign cmd_bwd   = p_bwd   | pend_bwd;
    assign cmd_pause = p_pause | pend_pause;
    assign cmd_home  = p_home;

    // Simultaneous fwd and bwd cancel each other.
    assign go_fwd = cmd_fwd & ~cmd_bwd;
    assign go_bwd = cmd_bwd & ~cmd_fwd;

    // Terminal count follows Speed immediately, so a faster setting whose
    // terminal is already passed expires on the current cycle.
    assign term = (32'(TICK_DIV) >> Speed) - 32'd1;
    assign hit  = is_run(state) && (32'(cnt) >= term);

    assign State = state;

    // Next-state, step and counter decisions.
    always_comb begin
        state_n      = state;
        pause_dir_n  = pause_dir;
        cnt_n        = cnt;
        pos_n        = Pos;
        dir_n        = DIR_HOLD;
        tick_n       = 1'b0;
        pend_fwd_n   = 1'b0;
        pend_bwd_n   = 1'b0;
        pend_pause_n = 1'b0;

        if (cmd_home) begin
            state_n     = ST_INIT;
            pause_dir_n = ST_FWD;
            pos_n       = 4'd0;
            cnt_n       = '0;
        end else begin
            case (state)
                ST_INIT: begin
                    dir_n        = DIR_HOME;
                    pos_n        = 4'd0;
                    cnt_n        = '0;
                    state_n      = ST_FWD;
                    pend_fwd_n   = cmd_fwd;
                    pend_bwd_n   = cmd_bwd;
                    pend_pause_n = cmd_pause;
                end
                ST_FWD, ST_BWD: begin
                    if (cmd_pause) begin
                        state_n     = ST_PAUSE;
                        pause_dir_n = state;
                    end else if (go_fwd) begin
                        state_n = ST_FWD;
                    end else if (go_bwd) begin
                        state_n = ST_BWD;
                    end
                end
                default: begin
                    if (cmd_pause) begin
                        state_n = pause_dir;
                    end else if (go_fwd) begin
                        state_n = ST_FWD;
                    end else if (go_bwd) begin
                        state_n = ST_BWD;
                    end
                end
            endcase

            // Counter runs only while moving; entering PAUSE freezes it.
            if (is_run(state) && is_run(state_n)) begin
                if (hit) begin
                    cnt_n  = '0;
                    tick_n = 1'b1;
                    if (state_n == ST_FWD) begin
                        if (Pos == POS_MAX) begin
                            if (Bounce) begin
                                dir_n   = DIR_DEC;
                                pos_n   = POS_MAX - 4'd1;
                                state_n = ST_BWD;
                            end else begin
                                dir_n = DIR_INC;
                                pos_n = 4'd0;
                            end
                        end else begin
                            dir_n = DIR_INC;
                            pos_n = Pos + 4'd1;
                        end
                    end else begin
                        if (Pos == 4'd0) begin
                            if (Bounce) begin
                                dir_n   = DIR_INC;
                                pos_n   = 4'd1;
                                state_n = ST_FWD;
                            end else begin
                                dir_n = DIR_DEC;
                                pos_n = POS_MAX;
                            end
                        end else begin
                            dir_n = DIR_DEC;
                            pos_n = Pos - 4'd1;
                        end
                    end
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
        end
    end

    // State, position, counter and registered outputs.
    always_ff @(posedge CLK_in) begin
        if (RST_in) begin
            state      <= ST_INIT;
            pause_dir  <= ST_FWD;
            cnt        <= '0;
            Pos        <= 4'd0;
            Dir        <= DIR_HOLD;
            Tick       <= 1'b0;
            pend_fwd   <= 1'b0;
            pend_bwd   <= 1'b0;
            pend_pause <= 1'b0;
        end else begin
            state      <= state_n;
            pause_dir  <= pause_dir_n;
            cnt        <= cnt_n;
            Pos        <= pos_n;
            Dir        <= dir_n;
            Tick       <= tick_n;
            pend_fwd   <= pend_fwd_n;
            pend_bwd   <= pend_bwd_n;
            pend_pause <= pend_pause_n;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_flow_ctrl.sv
// ============================================================================
// Module   : tb_flow_ctrl
// Brief    : Directed self-checking bench for flow_ctrl with TICK_DIV = 8.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_flow_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_fwd = 1'b0;
    logic       btn_bwd = 1'b0;
    logic       btn_pause = 1'b0;
    logic       btn_home = 1'b0;
    logic       bounce = 1'b0;
    logic [1:0] speed = 2'd0;
    logic [1:0] dir;
    logic [3:0] pos;
    logic [1:0] state;
    logic       tick;

    int errors = 0;
    int checks = 0;

    flow_ctrl #(.TICK_DIV(8)) dut (
        .CLK_in   (clk),
        .RST_in   (rst),
        .Btn_fwd  (btn_fwd),
        .Btn_bwd  (btn_bwd),
        .Btn_pause(btn_pause),
        .Btn_home (btn_home),
        .Bounce   (bounce),
        .Speed    (speed),
        .Dir      (dir),
        .Pos      (pos),
        .State    (state),
        .Tick     (tick)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counts negedges until Dir leaves HOLD (bounded).
    task automatic wait_step(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (dir == 2'b00 && n < 40);
    endtask

    initial begin
        int n;
        int tmp;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_dir", 32'(dir), 32'd0);
        chk("rst_pos", 32'(pos), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);

        // Release: INIT cycle then FWD with Dir=01 once
        rst = 1'b0;
        @(negedge clk);
        chk("init_dir", 32'(dir), 32'd1);
        chk("init_state", 32'(state), 32'd1);
        chk("init_pos", 32'(pos), 32'd0);

        // Forward run 0..15 then wrap to 0, period 8
        for (int k = 1; k <= 16; k++) begin
            wait_step(n);
            chk("fwd_period", 32'(n), 32'd8);
            chk("fwd_dir", 32'(dir), 32'd3);
            chk("fwd_tick", 32'(tick), 32'd1);
            chk("fwd_pos", 32'(pos), 32'(k & 15));
        end

        // Ping-pong at the top
        bounce = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            wait_step(n);
            chk("bnc_up_period", 32'(n), 32'd8);
            chk("bnc_up_pos", 32'(pos), 32'(k));
        end
        wait_step(n);
        chk("bnc_top_dir", 32'(dir), 32'd2);
        chk("bnc_top_pos", 32'(pos), 32'd14);
        chk("bnc_top_state", 32'(state), 32'd2);

        // Ping-pong at the bottom
        for (int k = 13; k >= 0; k--) begin
            wait_step(n);
            chk("bnc_dn_dir", 32'(dir), 32'd2);
            chk("bnc_dn_pos", 32'(pos), 32'(k));
        end
        wait_step(n);
        chk("bnc_bot_dir", 32'(dir), 32'd3);
        chk("bnc_bot_pos", 32'(pos), 32'd1);
        chk("bnc_bot_state", 32'(state), 32'd1);

        // Forward to 6, then bwd press without counter restart
        bounce = 1'b0;
        for (int k = 2; k <= 6; k++) begin
            wait_step(n);
            chk("run6_pos", 32'(pos), 32'(k));
        end
        btn_bwd = 1'b1;
        @(negedge clk);
        btn_bwd = 1'b0;
        wait_step(n);
        chk("bwd_cmd_period", 32'(n), 32'd7);
        chk("bwd_cmd_dir", 32'(dir), 32'd2);
        chk("bwd_cmd_pos", 32'(pos), 32'd5);
        chk("bwd_cmd_state", 32'(state), 32'd2);

        // Pause at 5 in BWD, hold for 50 cycles
        btn_pause = 1'b1;
        @(negedge clk);
        btn_pause = 1'b0;
        repeat (2) @(negedge clk);
        chk("pause_state", 32'(state), 32'd3);
        tmp = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (dir != 2'b00 || tick != 1'b0) tmp++;
        end
        chk("pause_hold_active", 32'(tmp), 32'd0);
        chk("pause_pos", 32'(pos), 32'd5);

        // Resume BWD from frozen counter
        btn_pause = 1'b1;
        @(negedge clk);
        btn_pause = 1'b0;
        wait_step(n);
        chk("resume_period", 32'(n), 32'd8);
        chk("resume_dir", 32'(dir), 32'd2);
        chk("resume_pos", 32'(pos), 32'd4);
        chk("resume_state", 32'(state), 32'd2);

        // Back to FWD and run to 9
        btn_fwd = 1'b1;
        @(negedge clk);
        btn_fwd = 1'b0;
        wait_step(n);
        chk("fwd_cmd_period", 32'(n), 32'd7);
        chk("fwd_cmd_dir", 32'(dir), 32'd3);
        chk("fwd_cmd_pos", 32'(pos), 32'd5);
        for (int k = 6; k <= 9; k++) begin
            wait_step(n);
            chk("run9_pos", 32'(pos), 32'(k));
        end

        // Home + pause + fwd together at 9: home wins
        btn_home = 1'b1;
        btn_pause = 1'b1;
        btn_fwd = 1'b1;
        @(negedge clk);
        btn_home = 1'b0;
        btn_pause = 1'b0;
        btn_fwd = 1'b0;
        repeat (2) @(negedge clk);
        chk("home_state_init", 32'(state), 32'd0);
        chk("home_pos", 32'(pos), 32'd0);
        chk("home_dir_hold", 32'(dir), 32'd0);
        @(negedge clk);
        chk("home_dir_home", 32'(dir), 32'd1);
        chk("home_state_fwd", 32'(state), 32'd1);
        @(negedge clk);
        chk("home_dir_once", 32'(dir), 32'd0);
        wait_step(n);
        chk("home_step_period", 32'(n), 32'd7);
        chk("home_step_pos", 32'(pos), 32'd1);

        // Speed 0 -> 3 with counter at 5
        repeat (5) @(negedge clk);
        speed = 2'd3;
        @(negedge clk);
        chk("spd_tick", 32'(tick), 32'd1);
        chk("spd_dir", 32'(dir), 32'd3);
        chk("spd_pos", 32'(pos), 32'd2);
        for (int k = 3; k <= 5; k++) begin
            @(negedge clk);
            chk("spd_fast_dir", 32'(dir), 32'd3);
            chk("spd_fast_pos", 32'(pos), 32'(k));
        end
        repeat (2) @(negedge clk);
        chk("spd_pos7", 32'(pos), 32'd7);

        // Reset mid-run for two cycles
        rst = 1'b1;
        speed = 2'd0;
        @(negedge clk);
        chk("mid_rst_pos", 32'(pos), 32'd0);
        chk("mid_rst_dir", 32'(dir), 32'd0);
        chk("mid_rst_state", 32'(state), 32'd0);
        chk("mid_rst_tick", 32'(tick), 32'd0);
        @(negedge clk);
        chk("mid_rst_dir2", 32'(dir), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_dir", 32'(dir), 32'd1);
        chk("post_rst_pos", 32'(pos), 32'd0);
        @(negedge clk);
        chk("post_rst_dir2", 32'(dir), 32'd0);

        // fwd and bwd together are ignored
        btn_fwd = 1'b1;
        btn_bwd = 1'b1;
        @(negedge clk);
        btn_fwd = 1'b0;
        btn_bwd = 1'b0;
        repeat (2) @(negedge clk);
        chk("both_ignored", 32'(state), 32'd1);

        // bwd pulse landing in the INIT cycle is applied next cycle
        btn_home = 1'b1;
        @(negedge clk);
        btn_home = 1'b0;
        btn_bwd = 1'b1;
        @(negedge clk);
        btn_bwd = 1'b0;
        @(negedge clk);
        chk("pend_init", 32'(state), 32'd0);
        @(negedge clk);
        chk("pend_fwd_state", 32'(state), 32'd1);
        chk("pend_home_dir", 32'(dir), 32'd1);
        @(negedge clk);
        chk("pend_bwd_state", 32'(state), 32'd2);
        wait_step(n);
        chk("pend_step_period", 32'(n), 32'd7);
        chk("pend_step_dir", 32'(dir), 32'd2);
        chk("pend_wrap_pos", 32'(pos), 32'd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
